edge_event_unit: RTL and testbench
==================================

Name: edge_event_unit

Overview:
- Parametrised, multi-channel successor to the single-edge detector used on the ARINC429 discrete inputs.
- Per channel:
  - synchronises an asynchronous input;
  - debounces it with a qualification counter;
  - detects rising, falling or both edges, selected per channel at run time;
  - produces a one-clock pulse, a sticky pending flag and a saturating event count.
- Feeds the discrete-input status/interrupt logic of the ARINC429 subsystem.

Parameters:
- CH, 8, number of independent channels.
- SYNC_STAGES, 2, synchroniser flops per channel (min 2).
- FILT_CYCLES, 3, consecutive clocks a new synchronised level must hold before acceptance (min 1; 1 = no filtering).
- EVT_CNT_W, 8, width of each per-channel event counter.
- INIT_VAL, 0, reset level for synchroniser and filtered level, all channels (1 bit, replicated).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- in  in  CH  raw asynchronous inputs.
- mode  in  2*CH  per-channel edge select, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both.
- irq_en  in  CH  per-channel interrupt enable.
- pend_clr  in  CH  per-channel pending clear, level-sensitive, sampled each clk.
- cnt_clr  in  CH  per-channel event counter clear.
- level  out  CH  filtered, debounced level.
- pulse  out  CH  one-clock edge pulse, registered.
- pending  out  CH  sticky event flags.
- evt_cnt  out  CH*EVT_CNT_W  per-channel counts, channel i at [i*EVT_CNT_W +: EVT_CNT_W].
- irq  out  1  OR over channels of (pending & irq_en).

Behaviour:
- Reset (async assert, sync release):
  - sync chain and level = INIT_VAL;
  - filter counters = 0; pulse = 0; pending = 0; evt_cnt = 0; irq = 0.
- Synchroniser: s[i] = in[i] delayed SYNC_STAGES clocks.
- Filter, per channel, each clk:
  - if s == level: fcnt <= 0;
  - else if fcnt == FILT_CYCLES-1: level <= s, fcnt <= 0, edge accepted;
  - else fcnt <= fcnt+1.
  - fcnt width = clog2(FILT_CYCLES) (min 1).
  - Any return to the old level before qualification restarts the count; the glitch is discarded.
- Latency: a stable change on in appears on level SYNC_STAGES+FILT_CYCLES clocks later. pulse asserts in the same cycle level changes.
- Pulse: registered.
  - pulse <= accepted & ((rise & mode[2i]) | (fall & mode[2i+1])).
  - High exactly one clock per accepted edge.
  - Mode 00: level still tracks; no pulse.
  - A mode change takes effect on the next accepted edge; it never disturbs filter state.
- Pending:
  - set by pulse; cleared by pend_clr;
  - set wins when pulse and pend_clr coincide (flag stays 1).
- Event counter:
  - +1 per pulse; saturates at 2^EVT_CNT_W-1 with no wrap.
  - cnt_clr alone -> 0.
  - cnt_clr with pulse in the same cycle -> 1.
- irq: combinational from pending and irq_en registers/inputs; no extra latency beyond pending.
- Input high during reset: after release, s reaches 1 and is treated as a rising edge from INIT_VAL. This is intended so no startup event is lost.
- Reset mid-qualification: filter count is lost; level reverts to INIT_VAL; no pulse is generated while rst_n is low.
- Channels are fully independent; simultaneous events on several channels are all recorded.

Test Plan:
- CH=4, SYNC=2, FILT=3, INIT_VAL=0, mode ch0=01. Hold in[0]=1 from cycle 0:
  - level[0] rises at cycle 5;
  - pulse[0]=1 for cycle 5 only;
  - pending[0]=1, evt_cnt[0]=1;
  - irq=1 iff irq_en[0].
- Glitch on ch1 (mode 11): in[1]=1 for 2 clocks, then 0, repeated 4 times:
  - level[1] stays 0; pulse never asserts;
  - evt_cnt[1]=0; pending[1]=0.
- ch2 mode 10: in[2] 0->1, held 10 clocks, then 1->0:
  - no pulse on the rise;
  - one pulse 5 clocks after the fall;
  - evt_cnt[2]=1.
  - Repeat with mode 11: evt_cnt[2]=2 (counter was cleared between runs).
- Same-cycle clears: drive pend_clr[3]=1 and cnt_clr[3]=1 in the pulse cycle with evt_cnt[3]=5 beforehand:
  - pending[3] stays 1; evt_cnt[3]=1.
  - Next cycle with pend_clr only: pending[3]=0.
- Saturation: EVT_CNT_W=2, 6 qualified edges on ch0 mode 11:
  - evt_cnt[0] goes 1,2,3,3,3,3.
- Reset mid-qualification: in[0] rises, rst_n pulsed low at cycle 3 for 1 clock:
  - all outputs 0 during reset;
  - after release, level[0] rises SYNC+FILT=5 clocks later with a single pulse.

Source files
------------

// File: rtl/edge_event_unit.sv
// Multi-channel discrete input edge unit: synchronise, debounce, detect edges, flag and count events.
// level/pulse change SYNC_STAGES+FILT_CYCLES clocks after a stable input change; pending/evt_cnt one clock after pulse.
module edge_event_unit #(
    parameter int   CH          = 8,
    parameter int   SYNC_STAGES = 2,
    parameter int   FILT_CYCLES = 3,
    parameter int   EVT_CNT_W   = 8,
    parameter logic INIT_VAL    = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [CH-1:0]           in,
    input  logic [2*CH-1:0]         mode,
    input  logic [CH-1:0]           irq_en,
    input  logic [CH-1:0]           pend_clr,
    input  logic [CH-1:0]           cnt_clr,
    output logic [CH-1:0]           level,
    output logic [CH-1:0]           pulse,
    output logic [CH-1:0]           pending,
    output logic [CH*EVT_CNT_W-1:0] evt_cnt,
    output logic                    irq
);
    localparam int FW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
    localparam logic [FW-1:0] FLAST = FW'(FILT_CYCLES - 1);
    localparam logic [EVT_CNT_W-1:0] CMAX = '1;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic [FW-1:0]          fcnt;
        logic                   lvl;
        logic                   pls;
        logic                   pnd;
        logic [EVT_CNT_W-1:0]   cnt;
        logic                   s;
        logic                   acc;
        logic                   hit;

        assign s   = sync_q[SYNC_STAGES-1];
        assign acc = (s != lvl) && (fcnt == FLAST);
        assign hit = acc && ((s && mode[2*i]) || (!s && mode[2*i+1]));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q <= {SYNC_STAGES{INIT_VAL}};
                fcnt   <= '0;
                lvl    <= INIT_VAL;
                pls    <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], in[i]};
                pls    <= hit;
                // Any sample matching the current level discards a partial qualification.
                if (s == lvl) begin
                    fcnt <= '0;
                end else if (fcnt == FLAST) begin
                    lvl  <= s;
                    fcnt <= '0;
                end else begin
                    fcnt <= fcnt + FW'(1);
                end
            end
        end

        // Set beats clear in both the flag and the counter.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pnd <= 1'b0;
                cnt <= '0;
            end else begin
                pnd <= pls || (pnd && !pend_clr[i]);
                if (cnt_clr[i])
                    cnt <= EVT_CNT_W'(pls);
                else if (pls && cnt != CMAX)
                    cnt <= cnt + EVT_CNT_W'(1);
            end
        end

        assign level[i]                          = lvl;
        assign pulse[i]                          = pls;
        assign pending[i]                        = pnd;
        assign evt_cnt[i*EVT_CNT_W +: EVT_CNT_W] = cnt;
    end

    assign irq = |(pending & irq_en);

endmodule

// File: tb/tb_edge_event_unit.sv
// Randomised scoreboard bench for edge_event_unit against a history-window reference model.
module tb_edge_event_unit;
    localparam int   CH   = 4;
    localparam int   SYNC = 2;
    localparam int   FILT = 3;
    localparam int   W    = 2;
    localparam logic IV   = 1'b0;
    localparam int   NCYC = 3000;

    typedef struct packed {
        logic [CH-1:0]   lvl;
        logic [CH-1:0]   pls;
        logic [CH-1:0]   pnd;
        logic [CH*W-1:0] cnt;
        logic            irq;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [CH-1:0]   in;
    logic [2*CH-1:0] mode;
    logic [CH-1:0]   irq_en;
    logic [CH-1:0]   pend_clr;
    logic [CH-1:0]   cnt_clr;
    logic [CH-1:0]   level;
    logic [CH-1:0]   pulse;
    logic [CH-1:0]   pending;
    logic [CH*W-1:0] evt_cnt;
    logic            irq;

    edge_event_unit #(.CH(CH), .SYNC_STAGES(SYNC), .FILT_CYCLES(FILT),
                      .EVT_CNT_W(W), .INIT_VAL(IV)) dut (
        .clk(clk), .rst_n(rst_n), .in(in), .mode(mode), .irq_en(irq_en),
        .pend_clr(pend_clr), .cnt_clr(cnt_clr), .level(level), .pulse(pulse),
        .pending(pending), .evt_cnt(evt_cnt), .irq(irq)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   started = 0;

    // Reference state: raw samples in flight through the synchroniser, recent synchronised samples.
    bit sq[CH][$];
    bit sh[CH][$];
    bit m_lvl[CH];
    bit m_pls[CH];
    bit m_pnd[CH];
    int m_cnt[CH];
    int hold[CH];

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            sq[c].delete();
            sh[c].delete();
            for (int k = 0; k < SYNC; k++) sq[c].push_back(IV);
            for (int k = 0; k < FILT; k++) sh[c].push_back(IV);
            m_lvl[c] = IV;
            m_pls[c] = 1'b0;
            m_pnd[c] = 1'b0;
            m_cnt[c] = 0;
        end
    endtask

    // Behaviour at one clock edge using the inputs held before it.
    task automatic model_edge();
        for (int c = 0; c < CH; c++) begin
            bit s, acc, np;
            s = sq[c].pop_front();
            sq[c].push_back(in[c]);
            void'(sh[c].pop_front());
            sh[c].push_back(s);
            acc = 1'b1;
            foreach (sh[c][k]) if (sh[c][k] == m_lvl[c]) acc = 1'b0;
            np = acc && ((s && mode[2*c]) || (!s && mode[2*c+1]));
            if (cnt_clr[c]) m_cnt[c] = m_pls[c] ? 1 : 0;
            else if (m_pls[c]) m_cnt[c] = (m_cnt[c] + 1 > (1 << W) - 1) ? (1 << W) - 1 : m_cnt[c] + 1;
            m_pnd[c] = m_pls[c] || (m_pnd[c] && !pend_clr[c]);
            if (acc) m_lvl[c] = s;
            m_pls[c] = np;
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e = '0;
        for (int c = 0; c < CH; c++) begin
            e.lvl[c] = m_lvl[c];
            e.pls[c] = m_pls[c];
            e.pnd[c] = m_pnd[c];
            e.cnt[c*W +: W] = W'(m_cnt[c]);
            if (m_pnd[c] && irq_en[c]) e.irq = 1'b1;
        end
        exp_q.push_back(e);
        started = 1;
    endtask

    always @(negedge clk) begin
        if (started) begin
            exp_t e;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard_empty t=%0t: no expected entry available", $time);
            end else begin
                e = exp_q.pop_front();
                if ({level, pulse, pending, evt_cnt, irq} !== e) begin
                    miscompares++;
                    $display("FAIL outputs t=%0t: got lvl=%b pls=%b pnd=%b cnt=%h irq=%b, want lvl=%b pls=%b pnd=%b cnt=%h irq=%b",
                             $time, level, pulse, pending, evt_cnt, irq,
                             e.lvl, e.pls, e.pnd, e.cnt, e.irq);
                end
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        in       = '0;
        mode     = 8'b11_11_10_01;
        irq_en   = 4'b0101;
        pend_clr = '0;
        cnt_clr  = '0;
        model_reset();
        for (int c = 0; c < CH; c++) hold[c] = 0;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            #1;
            if (rst_n) model_edge();
            if (cyc < 3) begin
                rst_n = 1'b0;
            end else if (cyc < 60) begin
                // Directed opening: steady rise on ch0, short glitches on ch1, long pulse on ch2.
                rst_n    = 1'b1;
                pend_clr = '0;
                cnt_clr  = '0;
                in[0]    = 1'b1;
                in[1]    = (cyc < 19) && (((cyc - 3) % 4) < 2);
                in[2]    = (cyc >= 10) && (cyc < 20);
                in[3]    = (cyc >= 30) && (cyc < 45);
            end else begin
                rst_n = ($urandom_range(0, 299) != 0);
                for (int c = 0; c < CH; c++) begin
                    if (hold[c] == 0) begin
                        in[c]   = ~in[c];
                        hold[c] = $urandom_range(1, FILT + 4);
                    end else begin
                        hold[c]--;
                    end
                    if ($urandom_range(0, 49) == 0) mode[2*c +: 2] = 2'($urandom_range(0, 3));
                    pend_clr[c] = ($urandom_range(0, 7) == 0);
                    cnt_clr[c]  = ($urandom_range(0, 29) == 0);
                    if ($urandom_range(0, 19) == 0) irq_en[c] = ~irq_en[c];
                end
            end
            if (!rst_n) model_reset();
            push_exp();
        end
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
